// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared debounce state encoding and counter sizing helper
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: synchroniser, 4-state Moore debouncer and registered edge pulses for one input bit
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DB_CYCLES   = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);
    localparam int CW = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
    logic [SYNC_STAGES-1:0] r_sync;
    db_state_t              r_state, w_state_nx;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic                   w_sync, w_rise_nx, w_fall_nx;
    assign w_sync = r_sync[SYNC_STAGES-1];
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_state   <= ZERO;
            r_cnt     <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            btn_level <= (w_state_nx == ONE) || (w_state_nx == WAIT0);
            btn_rise  <= w_rise_nx;
            btn_fall  <= w_fall_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        case (r_state)
            ZERO: if (w_sync) begin
                w_state_nx = WAIT1;
                w_cnt_nx   = '0;
            end
            WAIT1: if (!w_sync) w_state_nx = ZERO;
                else if (r_cnt == CNT_MAX) begin
                    w_state_nx = ONE;
                    w_rise_nx  = 1'b1;
                end else w_cnt_nx = r_cnt + 1'b1;
            ONE: if (!w_sync) begin
                w_state_nx = WAIT0;
                w_cnt_nx   = '0;
            end
            WAIT0: if (w_sync) w_state_nx = ONE;
                else if (r_cnt == CNT_MAX) begin
                    w_state_nx = ZERO;
                    w_fall_nx  = 1'b1;
                end else w_cnt_nx = r_cnt + 1'b1;
            default: w_state_nx = ZERO;
        endcase
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: N_CH independent synchronised, debounced inputs with rise/fall pulses
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DB_CYCLES   = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_rise (btn_rise[i]),
            .btn_fall (btn_fall[i])
        );
    end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Multi-channel front end for raw asynchronous inputs (push-buttons, switches) that feed the team's Moore state machines.
- Each channel is synchronised into the clk domain and debounced by a 4-state Moore FSM.
- Each channel produces a clean level plus one-cycle rise/fall pulses.
- Downstream FSM next-state logic consumes btn_rise/btn_fall directly as its transition conditions.

Parameters:
N_CH, 4, number of independent input channels
DB_CYCLES, 1000, consecutive stable synchronised samples required to accept a change (>=1)
SYNC_STAGES, 2, flip-flop depth of input synchroniser (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_raw  input  N_CH  asynchronous raw inputs, active high
btn_level  output  N_CH  debounced level per channel
btn_rise  output  N_CH  one-cycle pulse when btn_level goes 0->1
btn_fall  output  N_CH  one-cycle pulse when btn_level goes 1->0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; all state changes only on posedge clk.
- Reset (sampled high at a clk edge): synchroniser flops=0, state=ZERO, counter=0, btn_level=0, btn_rise=0, btn_fall=0. Reset overrides all other activity.
- Channels are fully independent. No cross-channel interaction.
- Synchroniser: SYNC_STAGES-deep shift register per channel. sync = last stage.
- Per-channel FSM states (2-bit):
  - ZERO: sync=1 -> WAIT1 with counter:=0; else stay.
  - WAIT1: sync=0 -> ZERO (glitch rejected, no pulse); sync=1 and counter==DB_CYCLES-1 -> ONE; else counter++.
  - ONE: sync=0 -> WAIT0 with counter:=0; else stay.
  - WAIT0: sync=1 -> ONE (glitch rejected, no pulse); sync=0 and counter==DB_CYCLES-1 -> ZERO; else counter++.
- Counter width = max(1, clog2(DB_CYCLES)). Counter never exceeds DB_CYCLES-1 and never wraps.
- btn_level is registered: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
- btn_rise is registered and asserted for exactly the one cycle following a WAIT1->ONE transition, coincident with btn_level first reading 1. btn_fall is the same for WAIT0->ZERO.
- btn_rise and btn_fall are never both high on the same channel. Either is high for at most one consecutive cycle.
- Latency: if btn_raw is first sampled high at edge E and stays high, btn_level=1 and btn_rise=1 after edge E+SYNC_STAGES+DB_CYCLES. Falling edges are symmetric.
- Minimum accepted pulse width: DB_CYCLES+1 consecutive samples. Pulses of DB_CYCLES samples or fewer produce no output change.
- Reset mid-operation: the state is abandoned with no pulse emitted. If the input is held high through reset, full latency applies afresh and btn_rise fires once.
- Bouncing within WAIT1/WAIT0 restarts qualification from the opposite stable state. The counter is cleared on every re-entry.

Decomposition:
- The shared package holds the state encoding constants ZERO=0, WAIT1=1, ONE=2, WAIT0=3, so that the downstream FSMs and the bench decode debug state identically.
- One sub-module, debounce_channel. It contains the synchroniser, FSM, counter and output registers for one bit.
- input_conditioner instantiates N_CH copies in a generate loop and concatenates their outputs.

Test Plan:
(Parameters: N_CH=4, DB_CYCLES=4, SYNC_STAGES=2 unless stated.)
1. Reset: hold reset 3 cycles with btn_raw=4'b1111 -> all outputs 0 throughout. Release at edge R -> btn_level=4'b1111 and btn_rise=4'b1111 for one cycle after edge R+6.
2. Clean press on ch0: btn_raw[0]=1 first sampled at edge E -> btn_level[0] rises after edge E+6 with btn_rise[0] high for exactly 1 cycle. Release sampled at F -> btn_level[0] falls after F+6 with btn_fall[0] pulse.
3. Glitch rejection on ch1: high for 4 samples then low -> btn_level[1], btn_rise[1] and btn_fall[1] stay 0. High for 5 samples -> accepted with one btn_rise[1].
4. Bounce on ch2: sequence 1,0,1,1,0,1,1,1,1,1 -> exactly one btn_rise[2], occurring 6 edges after the final 0->1 sample.
5. Reset mid-operation: assert reset while ch3 is in WAIT1 with counter=2 -> no pulse, outputs 0. With input still high after release, btn_rise[3] fires once after the full latency.
6. Simultaneous channels: ch0 pressed and ch1 released at the same edge -> btn_rise[0] and btn_fall[1] pulse in the same cycle. Channels 2 and 3 are unaffected.
